// File: rtl/pm_boot_loader_pkg.sv
// Shared definitions for the program-memory boot loader: FSM encoding and header size.
package pm_boot_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam int HDR_BYTES = 4;
  localparam int CNT_W     = 16;

endpackage

// File: rtl/pm_boot_loader_if.sv
// Byte-stream input and program-memory write port of the boot loader.
// The master side is the image source and PM observer; the loader is the slave.
interface pm_boot_loader_if #(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
);
  logic [7:0]          in_byte;
  logic                in_valid;
  logic                in_ready;
  logic                ld_pm_cslt;
  logic                ld_pm_wrb;
  logic [PMA_SIZE-1:0] ld_pm_add;
  logic [PMD_SIZE-1:0] ld_pm_dt;

  modport master (
    output in_byte, in_valid,
    input  in_ready, ld_pm_cslt, ld_pm_wrb, ld_pm_add, ld_pm_dt
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, ld_pm_cslt, ld_pm_wrb, ld_pm_add, ld_pm_dt
  );
endinterface

// File: rtl/pm_word_assembler.sv
// Packs big-endian stream bytes into PMD_SIZE-bit instruction words.
// word is the completed value including the byte currently presented.
module pm_word_assembler #(
  parameter int PMD_SIZE = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                byte_en,
  input  logic [7:0]          byte_in,
  output logic                word_rdy,
  output logic [PMD_SIZE-1:0] word
);

  localparam int BPW = PMD_SIZE / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [PMD_SIZE-1:0] sr_q;
  logic [CW-1:0]       cnt_q;

  assign word     = PMD_SIZE'({sr_q, byte_in});
  assign word_rdy = byte_en && (cnt_q == CW'(BPW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (byte_en) begin
      sr_q  <= word;
      cnt_q <= word_rdy ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pm_boot_loader.sv
// Program-memory boot loader: decodes a header plus instruction words and writes PM.
// Optional trailing XOR checksum is enabled with `define PM_BOOT_LOADER_CHECKSUM_EN.
module pm_boot_loader
  import pm_boot_loader_pkg::*;
#(
  parameter int PMA_SIZE = 16,
  parameter int PMD_SIZE = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  pm_boot_loader_if.slave   bus,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic              core_hold
);

  localparam logic [1:0] HDR_CNT_L = 2'd1;
  localparam logic [1:0] HDR_LAST  = 2'(HDR_BYTES - 1);

  state_t              state_q, state_d;
  logic [1:0]          hdr_idx_q;
  logic [7:0]          hdr_hi_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [PMA_SIZE-1:0] addr_q;
  logic [PMA_SIZE-1:0] pm_add_q;
  logic [PMD_SIZE-1:0] pm_dt_q;
  logic                start_ok;
  logic                xfer;
  logic                asm_en;
  logic                asm_rdy;
  logic [PMD_SIZE-1:0] asm_word;
  state_t              tail_state;

`ifdef PM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  assign tail_state = CHK;
`else
  assign tail_state = DONE;
`endif

  assign start_ok = ld_start && (state_q inside {IDLE, DONE, ERR});
  assign xfer     = bus.in_valid && bus.in_ready;
  assign asm_en   = bus.in_valid && (state_q == DATA);

  assign bus.in_ready   = (state_q inside {HDR, DATA, CHK});
  assign bus.ld_pm_cslt = (state_q == WRITE);
  assign bus.ld_pm_wrb  = (state_q == WRITE);
  assign bus.ld_pm_add  = pm_add_q;
  assign bus.ld_pm_dt   = pm_dt_q;

  assign ld_busy   = (state_q inside {HDR, DATA, WRITE, CHK});
  assign ld_done   = (state_q == DONE);
  assign core_hold = (state_q != DONE);
`ifdef PM_BOOT_LOADER_CHECKSUM_EN
  assign ld_err    = (state_q == ERR);
`else
  assign ld_err    = 1'b0;
`endif

  pm_word_assembler #(.PMD_SIZE(PMD_SIZE)) u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear    (start_ok),
    .byte_en  (asm_en),
    .byte_in  (bus.in_byte),
    .word_rdy (asm_rdy),
    .word     (asm_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (ld_start) state_d = HDR;
      HDR:   if (bus.in_valid && hdr_idx_q == HDR_LAST)
               state_d = (cnt_q != '0) ? DATA : tail_state;
      DATA:  if (asm_rdy) state_d = WRITE;
      // cnt_q still holds the pre-decrement count during WRITE
      WRITE: state_d = (cnt_q != CNT_W'(1)) ? DATA : tail_state;
`ifdef PM_BOOT_LOADER_CHECKSUM_EN
      CHK:   if (bus.in_valid)
               state_d = ((chk_q ^ bus.in_byte) == 8'h00) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_idx_q <= '0;
      hdr_hi_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      pm_add_q  <= '0;
      pm_dt_q   <= '0;
    end else if (start_ok) begin
      hdr_idx_q <= '0;
      hdr_hi_q  <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        HDR: if (bus.in_valid) begin
          hdr_idx_q <= hdr_idx_q + 1'b1;
          hdr_hi_q  <= bus.in_byte;
          if (hdr_idx_q == HDR_CNT_L) cnt_q  <= {hdr_hi_q, bus.in_byte};
          if (hdr_idx_q == HDR_LAST)  addr_q <= PMA_SIZE'({hdr_hi_q, bus.in_byte});
        end
        DATA: if (asm_rdy) begin
          pm_add_q <= addr_q;
          pm_dt_q  <= asm_word;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          cnt_q  <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PM_BOOT_LOADER_CHECKSUM_EN
  // Checksum covers header and payload; the trailing byte is compared, not folded in
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   chk_q <= '0;
    else if (start_ok)                            chk_q <= '0;
    else if (xfer && state_q inside {HDR, DATA})  chk_q <= chk_q ^ bus.in_byte;
  end
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: doc/pm_boot_loader.md
Name: pm_boot_loader

Overview:
Writer-side counterpart to the sequencer's program-memory read path. Receives a byte stream over a valid/ready interface and decodes a header plus instruction words. Writes each word into program memory through a chip-select/write-strobe port. While loading, the processor core is held in reset; the hold is released once the image is complete.

Parameters:
PMA_SIZE, 16, program memory address width
PMD_SIZE, 32, program memory data width; must be a multiple of 8
BPW, PMD_SIZE/8, bytes per instruction word (derived localparam, not overridable)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
ld_start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR
in_byte  input  8  stream byte
in_valid  input  1  in_byte is valid
in_ready  output  1  loader accepts in_byte this cycle (transfer = in_valid & in_ready)
ld_pm_cslt  output  1  PM chip select, high one cycle per write
ld_pm_wrb  output  1  PM write enable, 1 = write; high together with ld_pm_cslt
ld_pm_add  output  PMA_SIZE  PM write address
ld_pm_dt  output  PMD_SIZE  PM write data
ld_busy  output  1  load in progress
ld_done  output  1  sticky: load completed successfully
ld_err  output  1  sticky: load failed
core_hold  output  1  active-high hold of the core reset; 1 from reset until DONE

Behaviour:
- Reset (reset=0, async): state=IDLE, core_hold=1, all other outputs 0, counters and address cleared.
- Stream format, big-endian:
  - CNT_H, CNT_L: 16-bit word count N.
  - ADR_H, ADR_L: start address A, truncated to PMA_SIZE.
  - N words of BPW bytes each, MSB first.
- States: IDLE, HDR, DATA, WRITE, [CHK], DONE, ERR.
- IDLE: in_ready=0. On ld_start go to HDR, set ld_busy=1, clear ld_done and ld_err, set core_hold=1.
- HDR: in_ready=1. Takes 4 transfers. After the 4th, go to DATA if N≠0; if N=0 go to CHK (feature on) or DONE.
- DATA: in_ready=1. Shift bytes into a PMD_SIZE assembly register. When byte BPW of a word transfers, go to WRITE next cycle.
- WRITE, exactly 1 cycle:
  - in_ready=0.
  - ld_pm_cslt=1, ld_pm_wrb=1, ld_pm_add=current address, ld_pm_dt=assembled word.
  - Then address increments modulo 2^PMA_SIZE (wraps 0xFFFF→0x0000, no error) and remaining count decrements.
  - Next state: DATA if remaining≠0, else CHK/DONE.
- Latency: last byte accepted at cycle t → write strobe at t+1 → in_ready high again at t+2. Throughput is one word per BPW+1 cycles with in_valid held high.
- ld_pm_add and ld_pm_dt hold their last values outside WRITE. ld_pm_cslt and ld_pm_wrb are 0 outside WRITE.
- DONE: ld_busy=0, ld_done=1, core_hold=0 from the first DONE cycle. Stays in DONE until ld_start.
- ERR: ld_busy=0, ld_err=1, core_hold=1. Stays in ERR until ld_start.
- ld_start during HDR, DATA, WRITE or CHK is ignored.
- in_valid=0 stalls any state indefinitely; there is no timeout.
- Asserting reset mid-load aborts immediately to IDLE with core_hold=1. Partially written PM contents are left as-is.
- The count and remaining counter are 16 bits regardless of PMA_SIZE. N > 2^PMA_SIZE wraps and overwrites earlier words; this is legal.

Optional Feature:
PM_BOOT_LOADER_CHECKSUM_EN
- Defined:
  - Running 8-bit XOR over all header and payload bytes.
  - CHK state takes one trailing byte with in_ready=1.
  - If running XOR ^ byte == 0, go to DONE; otherwise go to ERR.
  - Checksum resets on ld_start.
- Undefined: no CHK state, no checksum logic. After the last write (or N=0) go straight to DONE; ERR is unreachable and ld_err is tied 0.

Decomposition:
- Shared package/header holds:
  - state encoding localparams: IDLE=0, HDR=1, DATA=2, WRITE=3, CHK=4, DONE=5, ERR=6
  - header byte count constant HDR_BYTES=4
- One sub-module is natural: pm_word_assembler.
  - Byte shift register plus byte counter 0..BPW-1.
  - Outputs word_rdy and word.
  - Cleared on ld_start.
- FSM, address and count counters, and checksum live in the top.

Test Plan:
- Reset then load N=2, A=0x0010, words 0x11223344 and 0xAABBCCDD, in_valid held high → writes (0x0010, 0x11223344) then (0x0011, 0xAABBCCDD), each strobe 1 cycle after its 4th byte; core_hold falls on the DONE cycle; ld_done=1.
- N=0, A=0x1234 → no ld_pm_cslt pulses, DONE reached right after the header (or after the checksum byte with the feature on).
- N=2, A=0xFFFF → writes to 0xFFFF then 0x0000; ld_err=0.
- Random in_valid gaps and a ld_start pulse mid-DATA → identical PM writes to the gap-free run; ld_start has no effect.
- reset asserted during the second word's bytes → all outputs return to reset values asynchronously; a subsequent full load succeeds.
- Feature on: correct XOR byte → DONE with core_hold=0; corrupted checksum byte → ERR with ld_err=1, core_hold=1; a later ld_start plus a good image → DONE.
